instr_feed_unit: RTL and testbench

- Instruction-side responder for CPU_LS. It holds a small program store and watches the CPU's pc_out.
- It drives the 16-bit instruction word and the one-cycle issue strobe en2, replacing the hand-timed stimulus that currently feeds the core.
- It sits between CPU_LS and a program-load port used by a bench or a boot loader.

---
 rtl/cpu_ls_pkg.sv | 18 +
 rtl/instr_feed_unit_if.sv | 32 +++
 rtl/instr_feed_unit_prog_store.sv | 36 +++
 rtl/instr_feed_unit.sv | 126 ++++++++++++
 tb/tb_instr_feed_unit.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ls_pkg.sv
// Shared definitions for the CPU_LS instruction-side feed logic.
package cpu_ls_pkg;

  localparam int INS_W = 16;

  // Instruction word driven whenever nothing valid is being issued.
  localparam logic [INS_W-1:0] NOP_WORD = 16'h0000;

  // Feed FSM state encoding; the numeric values are visible on the debug port.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

endpackage

// File: rtl/instr_feed_unit_if.sv
// Bundle between the instruction feed unit and its CPU / program-load side.
//
// Handshake semantics: there is no valid/ready pair. en2 is a one-cycle issue
// strobe with no back-pressure; the CPU must take ins in the cycle en2=1.
// ins is stable from the cycle en2 rises until the next fetch. prog_we is a
// fire-and-forget write strobe, accepted in every cycle and every state.
interface instr_feed_unit_if #(
  parameter int AW = 6
);
  logic           en_in;
  logic [15:0]    pc_in;
  logic           prog_we;
  logic [AW-1:0]  prog_addr;
  logic [15:0]    prog_data;
  logic [15:0]    ins;
  logic           en2;
  logic           busy;
  logic           halted;
  logic [15:0]    issue_cnt;

  // CPU / bench / boot-loader side.
  modport master (
    output en_in, pc_in, prog_we, prog_addr, prog_data,
    input  ins, en2, busy, halted, issue_cnt
  );

  // Feed unit side.
  modport slave (
    input  en_in, pc_in, prog_we, prog_addr, prog_data,
    output ins, en2, busy, halted, issue_cnt
  );
endinterface

// File: rtl/instr_feed_unit_prog_store.sv
// Program store: DEPTH x 16 register array, synchronous write, combinational
// write-first read so a same-cycle write to the fetched address is seen.
module prog_store #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem_q [DEPTH];
  logic        waddr_ok;

  // Ignore writes that fall outside the populated part of the address space.
  assign waddr_ok = ({1'b0, waddr} < (AW + 1)'(DEPTH));

  // Store update; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we && waddr_ok) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port with bypass of the write happening in the same cycle.
  always_comb begin
    rdata = mem_q[raddr];
    if (we && (waddr == raddr)) begin
      rdata = wdata;
    end
  end

endmodule

// File: rtl/instr_feed_unit.sv
// Instruction feed unit: fetches the word addressed by the CPU's PC from a
// local program store and issues it with a one-cycle en2 strobe every GAP
// cycles. An out-of-range PC parks the unit in HALT until reset.
module instr_feed_unit
  import cpu_ls_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  // Cycles between en2 pulses; legal range 3..255.
  parameter int GAP   = 4,
  parameter logic [INS_W-1:0] NOP_WORD = cpu_ls_pkg::NOP_WORD
) (
  input  logic                clk,
  input  logic                rst,
  instr_feed_unit_if.slave    bus,
  output state_e              dbg_state
);

  // FETCH + ISSUE take two cycles, WAIT covers the remaining GAP-2 cycles,
  // counting GAP-3 down to 0 inclusive.
  localparam logic [7:0] WAIT_LOAD = 8'(GAP - 3);

  state_e             state_q, state_d;
  logic [INS_W-1:0]   ins_q, ins_d;
  logic               en2_q, en2_d;
  logic               halted_q, halted_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [7:0]         wait_q, wait_d;

  logic [INS_W-1:0]   rdata;
  logic               pc_oob;

  prog_store #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_store (
    .clk   (clk),
    .we    (bus.prog_we),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .raddr (bus.pc_in[AW-1:0]),
    .rdata (rdata)
  );

  // The full 16-bit PC is compared, so high PC bits never alias into the store.
  assign pc_oob = (32'(bus.pc_in) >= 32'(DEPTH));

  // State and output registers; everything clears asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ins_q    <= NOP_WORD;
      en2_q    <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= 16'd0;
      wait_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      ins_q    <= ins_d;
      en2_q    <= en2_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
    end
  end

  // Next-state logic; en2 and issue_cnt change on the edge entering ISSUE so
  // the strobe, the count and the fetched word all appear together.
  always_comb begin
    state_d  = state_q;
    ins_d    = ins_q;
    en2_d    = 1'b0;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.en_in) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!bus.en_in) begin
          state_d = ST_IDLE;
        end else if (pc_oob) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
          ins_d    = NOP_WORD;
        end else begin
          state_d = ST_ISSUE;
          ins_d   = rdata;
          en2_d   = 1'b1;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      ST_ISSUE: begin
        wait_d  = WAIT_LOAD;
        state_d = bus.en_in ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        if (!bus.en_in) begin
          state_d = ST_IDLE;
        end else if (wait_q == 8'd0) begin
          state_d = ST_FETCH;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.ins       = ins_q;
  assign bus.en2       = en2_q;
  assign bus.halted    = halted_q;
  assign bus.issue_cnt = cnt_q;
  assign bus.busy      = (state_q == ST_FETCH) || (state_q == ST_ISSUE) ||
                         (state_q == ST_WAIT);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_instr_feed_unit.sv
// Directed + randomized bench for instr_feed_unit against a word-level model:
// a copy of the program store and an expected issue count.
module tb_instr_feed_unit;
  import cpu_ls_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int GAP   = 4;

  logic   clk;
  logic   rst;
  state_e dbg_state;

  instr_feed_unit_if #(.AW(AW)) bus ();

  instr_feed_unit #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .GAP   (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  logic [15:0] exp_mem [DEPTH];
  logic [15:0] exp_q [$];
  int          exp_cnt;
  int          since;
  int          tests;
  int          fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    since++;
  endtask

  // Waits (bounded) for the next en2 pulse and scores it against the model.
  task automatic expect_pulse(input string tag, input int exp_gap);
    int          n;
    bit          seen;
    logic [15:0] want;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (bus.en2 === 1'b1) seen = 1'b1;
    end
    want    = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    exp_cnt = (exp_cnt + 1) % 65536;
    chk({tag, "_gap"}, 32'(since), 32'(exp_gap));
    chk({tag, "_ins"}, 32'(bus.ins), 32'(want));
    chk({tag, "_cnt"}, 32'(bus.issue_cnt), 32'(exp_cnt));
    since = 0;
  endtask

  // Counts en2 pulses over a window; used where none may occur.
  task automatic count_en2(input int cycles, output int hits);
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.en2 === 1'b1) hits++;
    end
  endtask

  initial begin
    int p;
    int hits;
    tests   = 0;
    fails   = 0;
    exp_cnt = 0;
    since   = 0;

    // reset release
    rst           = 1'b1;
    bus.en_in     = 1'b0;
    bus.pc_in     = 16'd0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = 16'd0;
    repeat (4) tick();
    chk("rst_ins", 32'(bus.ins), 32'h0000);
    chk("rst_en2", 32'(bus.en2), 32'd0);
    chk("rst_cnt", 32'(bus.issue_cnt), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_state", 32'(dbg_state), 32'(ST_IDLE));

    // load program: fixed words where the plan names them, random elsewhere
    for (int a = 0; a < DEPTH; a++) begin
      logic [15:0] w;
      case (a)
        0:       w = 16'h0401;
        1:       w = 16'h2401;
        2:       w = 16'h2402;
        5:       w = 16'hC003;
        default: w = 16'($urandom);
      endcase
      exp_mem[a]    = w;
      bus.prog_we   = 1'b1;
      bus.prog_addr = 6'(a);
      bus.prog_data = w;
      tick();
    end
    bus.prog_we = 1'b0;
    tick();

    // linear program, pc follows the issue count
    bus.pc_in = 16'd0;
    bus.en_in = 1'b1;
    since     = 0;
    exp_q.push_back(exp_mem[0]);
    expect_pulse("lin0", 2);
    for (int k = 1; k < 3; k++) begin
      bus.pc_in = 16'(exp_cnt);
      exp_q.push_back(exp_mem[exp_cnt]);
      expect_pulse($sformatf("lin%0d", k), GAP);
    end

    // jump
    bus.pc_in = 16'd5;
    exp_q.push_back(exp_mem[5]);
    expect_pulse("jump5", GAP);

    // random jumps including both ends of the store
    for (int k = 0; k < 8; k++) begin
      p = (k == 0) ? DEPTH - 1 : (k == 1) ? 0 : int'($urandom_range(0, DEPTH - 1));
      bus.pc_in = 16'(p);
      exp_q.push_back(exp_mem[p]);
      expect_pulse($sformatf("rnd%0d", k), GAP);
    end

    // write-first collision in the fetch cycle
    bus.pc_in = 16'd2;
    repeat (3) tick();
    chk("wf_state", 32'(dbg_state), 32'(ST_FETCH));
    bus.prog_we   = 1'b1;
    bus.prog_addr = 6'd2;
    bus.prog_data = 16'hD022;
    exp_mem[2]    = 16'hD022;
    exp_q.push_back(16'hD022);
    expect_pulse("wf", GAP);
    bus.prog_we = 1'b0;

    // en_in drop during WAIT, then re-raise
    tick();
    bus.en_in = 1'b0;
    tick();
    chk("drop_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("drop_busy", 32'(bus.busy), 32'd0);
    count_en2(6, hits);
    chk("drop_no_en2", 32'(hits), 32'd0);
    chk("drop_ins_kept", 32'(bus.ins), 32'h0000_D022);
    p         = int'($urandom_range(0, DEPTH - 1));
    bus.pc_in = 16'(p);
    bus.en_in = 1'b1;
    since     = 0;
    exp_q.push_back(exp_mem[p]);
    expect_pulse("reraise", 2);

    // asynchronous reset during WAIT
    tick();
    rst = 1'b1;
    #1;
    chk("arst_cnt", 32'(bus.issue_cnt), 32'd0);
    chk("arst_en2", 32'(bus.en2), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_ins", 32'(bus.ins), 32'h0000);
    exp_cnt = 0;
    tick();
    tick();
    rst = 1'b0;

    // out of range after a valid issue
    bus.pc_in = 16'd0;
    since     = 0;
    exp_q.push_back(exp_mem[0]);
    expect_pulse("pre_halt", 2);
    bus.pc_in = 16'(DEPTH);
    repeat (4) tick();
    chk("halt_flag", 32'(bus.halted), 32'd1);
    chk("halt_ins", 32'(bus.ins), 32'(NOP_WORD));
    chk("halt_state", 32'(dbg_state), 32'(ST_HALT));
    chk("halt_busy", 32'(bus.busy), 32'd0);
    bus.pc_in = 16'd1;
    count_en2(12, hits);
    chk("halt_no_en2", 32'(hits), 32'd0);
    chk("halt_sticky", 32'(bus.halted), 32'd1);
    chk("halt_cnt", 32'(bus.issue_cnt), 32'(exp_cnt));
    rst = 1'b1;
    #1;
    chk("halt_clr", 32'(bus.halted), 32'd0);
    exp_cnt = 0;
    tick();
    rst = 1'b0;

    // random large PCs halt straight from IDLE
    for (int k = 0; k < 3; k++) begin
      p = (k == 0) ? 65535 : int'($urandom_range(DEPTH, 65535));
      bus.pc_in = 16'(p);
      bus.en_in = 1'b1;
      tick();
      tick();
      chk($sformatf("oob%0d_halted", k), 32'(bus.halted), 32'd1);
      chk($sformatf("oob%0d_en2", k), 32'(bus.en2), 32'd0);
      rst = 1'b1;
      bus.en_in = 1'b0;
      tick();
      rst = 1'b0;
    end
    chk("final_halted", 32'(bus.halted), 32'd0);
    chk("final_cnt", 32'(bus.issue_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
